multilane_deserializer: RTL and testbench

Parametrised successor to the single-bit serial receiver. Runs entirely in the system clock domain: a bit_en strobe qualifies each serial beat, and each beat carries LANES bits in parallel. Framed words are assembled LSB-first or MSB-first and buffered in a small output FIFO with a valid/ready handshake. Sticky overflow and framing-error flags are provided. Sits between the off-chip/link serial interface and the systolic-array input/weight loaders.

---
 rtl/multilane_deserializer.sv | 160 ++++++++++++++++
 tb/tb_multilane_deserializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multilane_deserializer.sv
// Multi-lane serial-to-parallel receiver with framing and an output FIFO.
// Each bit_en beat carries LANES bits. frame_sync marks beat 0 of a word.
// A completed word is pushed into a small FIFO that has a valid/ready output.
// Handshake: the head word transfers on any rising edge where out_valid=1
// and out_ready=1. out_valid depends only on FIFO occupancy, never on out_ready.
module multilane_deserializer #(
   parameter int WIDTH      = 32,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            bit_en,
   input  logic [LANES-1:0]                serial_data,
   input  logic                            frame_sync,
   output logic [WIDTH-1:0]                out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   output logic                            overflow,
   output logic                            frame_err,
   input  logic                            clear_flags
);
   localparam int BEATS = WIDTH / LANES;
   localparam int CW    = $clog2(BEATS) + 1;
   localparam int LW    = $clog2(FIFO_DEPTH + 1);
   localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   // state is a named register so checkers can bind to it directly
   state_t           state, state_nxt;
   logic [CW-1:0]    beat_cnt, beat_cnt_nxt;
   logic [WIDTH-1:0] asm_word, asm_nxt, merged, push_word;
   logic             push, frame_evt;

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [LW-1:0]    count;
   logic             pop, full, do_push, ovf_evt;

   // Write one beat into a word at the slot for beat index k
   function automatic logic [WIDTH-1:0] place(input logic [WIDTH-1:0] base, input int k,
                                              input logic [LANES-1:0] d);
      logic [WIDTH-1:0] w;
      int off;
      w   = base;
      off = MSB_FIRST ? (WIDTH - (k + 1) * LANES) : (k * LANES);
      w[off +: LANES] = d;
      return w;
   endfunction

   // Pointer advance that wraps correctly for non-power-of-two depths
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Framing FSM: next state, beat counter, assembly register and push request
   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      asm_nxt      = asm_word;
      push         = 1'b0;
      push_word    = '0;
      frame_evt    = 1'b0;
      merged       = place(asm_word, int'(beat_cnt), serial_data);
      if (bit_en) begin
         case (state)
            IDLE: begin
               if (frame_sync) begin
                  if (BEATS == 1) begin
                     push      = 1'b1;
                     push_word = place('0, 0, serial_data);
                     asm_nxt   = '0;
                  end else begin
                     asm_nxt      = place('0, 0, serial_data);
                     beat_cnt_nxt = CW'(1);
                     state_nxt    = RECV;
                  end
               end
            end
            RECV: begin
               if (frame_sync) begin
                  // Early frame start: drop the partial word, restart at beat 0
                  frame_evt    = 1'b1;
                  asm_nxt      = place('0, 0, serial_data);
                  beat_cnt_nxt = CW'(1);
               end else if (beat_cnt == CW'(BEATS - 1)) begin
                  push         = 1'b1;
                  push_word    = merged;
                  asm_nxt      = '0;
                  beat_cnt_nxt = '0;
                  state_nxt    = IDLE;
               end else begin
                  asm_nxt      = merged;
                  beat_cnt_nxt = beat_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Framing FSM registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat_cnt <= '0;
         asm_word <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
         asm_word <= asm_nxt;
      end
   end

   assign out_valid  = (count != '0);
   assign fifo_level = count;
   assign full       = (count == LW'(FIFO_DEPTH));
   assign pop        = out_valid & out_ready;
   // A full FIFO still accepts a word when the head leaves on the same edge
   assign do_push    = push & (~full | pop);
   assign ovf_evt    = push & full & ~pop;
   assign out_data   = out_valid ? mem[rd_ptr] : '0;

   // FIFO storage; contents are only visible through the occupancy-gated head
   always_ff @(posedge clk) begin
      if (rst_n && do_push) mem[wr_ptr] <= push_word;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)     rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new event on the clearing edge wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow  <= ovf_evt   | (overflow  & ~clear_flags);
         frame_err <= frame_evt | (frame_err & ~clear_flags);
      end
   end

endmodule

// File: tb/tb_multilane_deserializer.sv
// Bench for multilane_deserializer: directed table, corner sequences and
// random traffic scored against a queue-based reference model.
module tb_multilane_deserializer;
   localparam int WIDTH = 32;
   localparam int LANES = 4;
   localparam int DEPTH = 4;
   localparam int BEATS = WIDTH / LANES;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n = 1'b0;
   logic             bit_en = 1'b0;
   logic [LANES-1:0] serial_data = '0;
   logic             frame_sync = 1'b0;
   logic             out_ready = 1'b0;
   logic             clear_flags = 1'b0;

   logic [WIDTH-1:0] out_data, msb_data;
   logic             out_valid, msb_valid;
   logic [2:0]       fifo_level, msb_level;
   logic             overflow, frame_err, msb_overflow, msb_frame_err;

   // single-lane instance inputs/outputs
   logic       l1_en = 1'b0;
   logic [0:0] l1_data = '0;
   logic       l1_fs = 1'b0;
   logic       l1_ready = 1'b1;
   logic       l1_clr = 1'b0;
   logic [7:0] l1_out;
   logic       l1_valid, l1_ovf, l1_ferr;
   logic [2:0] l1_level;

   multilane_deserializer #(.WIDTH(WIDTH), .LANES(LANES), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .serial_data(serial_data), .frame_sync(frame_sync),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
      .overflow(overflow), .frame_err(frame_err), .clear_flags(clear_flags));

   multilane_deserializer #(.WIDTH(WIDTH), .LANES(LANES), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .serial_data(serial_data), .frame_sync(frame_sync),
      .out_data(msb_data), .out_valid(msb_valid), .out_ready(out_ready), .fifo_level(msb_level),
      .overflow(msb_overflow), .frame_err(msb_frame_err), .clear_flags(clear_flags));

   multilane_deserializer #(.WIDTH(8), .LANES(1), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .bit_en(l1_en), .serial_data(l1_data), .frame_sync(l1_fs),
      .out_data(l1_out), .out_valid(l1_valid), .out_ready(l1_ready), .fifo_level(l1_level),
      .overflow(l1_ovf), .frame_err(l1_ferr), .clear_flags(l1_clr));

   // ---------------- scoreboard / reference model ----------------
   int errors = 0;
   int checks = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] exp_q_msb[$];
   logic [LANES-1:0] mdl_beats[$];
   bit mdl_ovf = 1'b0;
   bit mdl_ferr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: collect beats in a list, build the word arithmetically once complete
   task automatic model_edge();
      bit pop, push, ferr_evt, ovf_evt;
      logic [WIDTH-1:0] wl, wm;
      pop = (exp_q.size() != 0) && out_ready;
      push = 1'b0; ferr_evt = 1'b0; ovf_evt = 1'b0; wl = '0; wm = '0;
      if (!rst_n) begin
         mdl_beats.delete(); exp_q.delete(); exp_q_msb.delete();
         mdl_ovf = 1'b0; mdl_ferr = 1'b0;
         return;
      end
      if (bit_en) begin
         if (frame_sync) begin
            if (mdl_beats.size() != 0) ferr_evt = 1'b1;
            mdl_beats.delete();
            mdl_beats.push_back(serial_data);
         end else if (mdl_beats.size() != 0) begin
            mdl_beats.push_back(serial_data);
            if (mdl_beats.size() == BEATS) begin
               for (int k = 0; k < BEATS; k++) begin
                  wl = wl | (WIDTH'(mdl_beats[k]) << (k * LANES));
                  wm = wm | (WIDTH'(mdl_beats[k]) << (WIDTH - (k + 1) * LANES));
               end
               push = 1'b1;
               mdl_beats.delete();
            end
         end
      end
      if (pop) begin
         exp_q.delete(0);
         exp_q_msb.delete(0);
      end
      if (push) begin
         if (exp_q.size() < DEPTH) begin
            exp_q.push_back(wl);
            exp_q_msb.push_back(wm);
         end else ovf_evt = 1'b1;
      end
      mdl_ovf  = ovf_evt  | (mdl_ovf  & !clear_flags);
      mdl_ferr = ferr_evt | (mdl_ferr & !clear_flags);
   endtask

   task automatic check_model();
      chk("level", 32'(fifo_level), 32'(exp_q.size()));
      chk("valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("msb_valid", 32'(msb_valid), 32'(exp_q_msb.size() != 0));
      if (exp_q.size() != 0) begin
         chk("data", out_data, exp_q[0]);
         chk("msb_data", msb_data, exp_q_msb[0]);
      end
      chk("overflow", 32'(overflow), 32'(mdl_ovf));
      chk("frame_err", 32'(frame_err), 32'(mdl_ferr));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic idle(input int n);
      bit_en = 1'b0; frame_sync = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_beats(input logic [WIDTH-1:0] w, input int nbeats, input int gap,
                             input bit pop_on_last);
      for (int k = 0; k < nbeats; k++) begin
         bit_en = 1'b1;
         serial_data = w[k*LANES +: LANES];
         frame_sync = (k == 0);
         if (pop_on_last && k == nbeats - 1) out_ready = 1'b1;
         step();
         if (pop_on_last && k == nbeats - 1) out_ready = 1'b0;
         if (gap > 0 && k != nbeats - 1) idle(gap);
      end
      bit_en = 1'b0; frame_sync = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [LANES-1:0] nib;
      bit               en;
      bit               fs;
      bit               exp_valid;
      int               exp_level;
      logic [WIDTH-1:0] exp_lsb;
      logic [WIDTH-1:0] exp_msb;
   } vec_t;
   vec_t tbl[10];

   logic [WIDTH-1:0] words[5];

   initial begin
      for (int i = 0; i < 10; i++) begin
         tbl[i].nib = (i < 8) ? LANES'(i + 1) : '0;
         tbl[i].en = (i < 8);
         tbl[i].fs = (i == 0);
         tbl[i].exp_valid = (i == 7);
         tbl[i].exp_level = (i == 7) ? 1 : 0;
         tbl[i].exp_lsb = 32'h8765_4321;
         tbl[i].exp_msb = 32'h1234_5678;
      end

      // reset
      rst_n = 1'b0;
      step(); step();
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_level", 32'(fifo_level), 32'h0);
      chk("rst_flags", {30'h0, overflow, frame_err}, 32'h0);
      chk("rst_l1_valid", 32'(l1_valid), 32'h0);
      rst_n = 1'b1;
      idle(1);

      // table: nibbles 1..8, consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bit_en = tbl[i].en; frame_sync = tbl[i].fs; serial_data = tbl[i].nib;
         step();
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].exp_level));
         if (tbl[i].exp_valid) begin
            chk($sformatf("tbl%0d_lsb", i), out_data, tbl[i].exp_lsb);
            chk($sformatf("tbl%0d_msb", i), msb_data, tbl[i].exp_msb);
         end
      end

      // single lane, LSB first: 1,0,1,1,0,0,0,0 -> 0x0D
      bit_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         l1_en = 1'b1; l1_fs = (k == 0); l1_data = 1'((8'b0000_1101 >> k) & 8'h1);
         step();
      end
      l1_en = 1'b0; l1_fs = 1'b0;
      chk("l1_valid", 32'(l1_valid), 32'h1);
      chk("l1_data", 32'(l1_out), 32'h0D);
      step();
      chk("l1_popped", 32'(l1_valid), 32'h0);

      // early frame_sync after 3 beats, then a full word
      out_ready = 1'b0;
      send_beats(32'hFFFF_FFFF, 3, 0, 1'b0);
      send_beats(32'h3456_789A, BEATS, 0, 1'b0);
      chk("ferr_set", 32'(frame_err), 32'h1);
      chk("ferr_level", 32'(fifo_level), 32'h1);
      chk("ferr_word", out_data, 32'h3456_789A);
      clear_flags = 1'b1; step(); clear_flags = 1'b0;
      chk("ferr_cleared", 32'(frame_err), 32'h0);
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // overflow: five words into a four-entry FIFO
      for (int i = 0; i < 5; i++) begin
         words[i] = $urandom();
         send_beats(words[i], BEATS, 0, 1'b0);
      end
      chk("ovf_level", 32'(fifo_level), 32'h4);
      chk("ovf_set", 32'(overflow), 32'h1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_pop%0d", i), out_data, words[i]);
         step();
      end
      chk("ovf_drained", 32'(out_valid), 32'h0);
      out_ready = 1'b0;
      clear_flags = 1'b1; step(); clear_flags = 1'b0;

      // full FIFO with a pop on the completing edge
      for (int i = 0; i < 5; i++) begin
         words[i] = $urandom();
         send_beats(words[i], BEATS, 0, i == 4);
      end
      chk("fullpop_level", 32'(fifo_level), 32'h4);
      chk("fullpop_no_ovf", 32'(overflow), 32'h0);
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("fullpop_pop%0d", i), out_data, words[i]);
         step();
      end
      out_ready = 1'b0;

      // reset mid-word, then a clean word with idle gaps between beats
      send_beats(32'h2222_2222, 5, 0, 1'b0);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      send_beats(32'h1111_1111, BEATS, 3, 1'b0);
      chk("rstmid_level", 32'(fifo_level), 32'h1);
      chk("rstmid_word", out_data, 32'h1111_1111);
      chk("rstmid_flags", {30'h0, overflow, frame_err}, 32'h0);
      out_ready = 1'b1; step();

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bit_en = ($urandom_range(0, 3) != 0);
         serial_data = LANES'($urandom());
         frame_sync = (mdl_beats.size() == 0) ? ($urandom_range(0, 3) != 0)
                                              : ($urandom_range(0, 19) == 0);
         out_ready = $urandom_range(0, 1);
         clear_flags = ($urandom_range(0, 29) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
         step();
      end
      rst_n = 1'b1; clear_flags = 1'b0;
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
